// File: rtl/bram_result_reader_pkg.sv
// rtl/bram_result_reader_pkg.sv - shared state encoding and sizing helpers for the result reader
package bram_result_reader_pkg;

  // Encoding shared with the multiply data mover's control FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int CNT_DEF        = 31;
  localparam int DWIDTH_DEF     = 32;
  localparam int AWIDTH_DEF     = 12;
  localparam int FIFO_DEPTH_DEF = 2;

  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_result_reader_if.sv
// rtl/bram_result_reader_if.sv - valid/ready result stream between reader and host/DMA sink
interface bram_result_reader_if #(
  parameter int DWIDTH = 32
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/bram_result_reader_sync_fifo.sv
// rtl/bram_result_reader_sync_fifo.sv - small synchronous FIFO absorbing the BRAM read latency
module bram_result_reader_sync_fifo
  import bram_result_reader_pkg::*;
#(
  parameter  int DWIDTH = 32,
  parameter  int DEPTH  = 2,
  localparam int CW     = fifo_cnt_width(DEPTH),
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bram_result_reader.sv
// rtl/bram_result_reader.sv - drains N words from result BRAM onto a valid/ready stream
module bram_result_reader
  import bram_result_reader_pkg::*;
#(
  parameter int CNT        = CNT_DEF,
  parameter int DWIDTH     = DWIDTH_DEF,
  parameter int AWIDTH     = AWIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [CNT-1:0]    i_num_cnt,
  output logic              o_idle,
  output logic              o_running,
  output logic              o_done,
  output logic [AWIDTH-1:0] addr_b1,
  output logic              ce_b1,
  output logic              we_b1,
  output logic [DWIDTH-1:0] d0_b1,
  input  logic [DWIDTH-1:0] q0_b1,
  bram_result_reader_if.master strm
);

  localparam int CW = fifo_cnt_width(FIFO_DEPTH);

  state_t            state;
  logic [CNT-1:0]    num_cnt;
  logic [CNT-1:0]    rd_cnt;
  logic [CNT-1:0]    wr_cnt;
  logic              inflight;
  logic [CW-1:0]     fifo_cnt;
  logic [DWIDTH-1:0] fifo_head;
  logic              pop;
  logic              last_beat;
  logic [CW:0]       credit_used;

  assign pop          = strm.m_valid && strm.m_ready;
  assign strm.m_valid = (fifo_cnt != '0);
  assign strm.m_data  = strm.m_valid ? fifo_head : '0;
  assign last_beat    = (wr_cnt == num_cnt - 1'b1);
  assign strm.m_last  = strm.m_valid && last_beat;

  // Reserve a FIFO slot for every read still in flight so the push never overflows.
  assign credit_used = {1'b0, fifo_cnt} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign ce_b1       = (state == S_RUN) && (rd_cnt < num_cnt)
                    && (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign addr_b1     = rd_cnt[AWIDTH-1:0];
  assign we_b1       = 1'b0;
  assign d0_b1       = '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      o_idle    <= 1'b1;
      o_running <= 1'b0;
      o_done    <= 1'b0;
      num_cnt   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= ce_b1;
      case (state)
        S_IDLE: begin
          if (i_run) begin
            num_cnt <= i_num_cnt;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            o_idle  <= 1'b0;
            if (i_num_cnt == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state     <= S_RUN;
              o_running <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ce_b1) rd_cnt <= rd_cnt + 1'b1;
          if (pop)   wr_cnt <= wr_cnt + 1'b1;
          if (pop && strm.m_last) begin
            state     <= S_DONE;
            o_running <= 1'b0;
            o_done    <= 1'b1;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_idle <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          o_idle    <= 1'b1;
          o_running <= 1'b0;
          o_done    <= 1'b0;
        end
      endcase
    end
  end

  bram_result_reader_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (q0_b1),
    .pop       (pop),
    .count     (fifo_cnt),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_bram_result_reader.sv
// tb/tb_bram_result_reader.sv - self-checking bench for bram_result_reader
module tb_bram_result_reader;

  localparam int CNT   = 31;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 2;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_run = 1'b0;
  logic [CNT-1:0] i_num_cnt = '0;
  logic          o_idle, o_running, o_done;
  logic [AW-1:0] addr_b1;
  logic          ce_b1, we_b1;
  logic [DW-1:0] d0_b1;
  logic [DW-1:0] q0_b1 = '0;

  bram_result_reader_if #(.DWIDTH(DW)) strm ();

  bram_result_reader #(
    .CNT(CNT), .DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .o_idle    (o_idle),
    .o_running (o_running),
    .o_done    (o_done),
    .addr_b1   (addr_b1),
    .ce_b1     (ce_b1),
    .we_b1     (we_b1),
    .d0_b1     (d0_b1),
    .q0_b1     (q0_b1),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [MEMSZ];
  always @(posedge clk) if (ce_b1) q0_b1 <= mem[addr_b1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode: 0 always ready, 1 ready pattern 1,0,0, 2 random ready, 3 not ready until cycle 13
  typedef struct {
    int num;
    int mode;
    int exp_done;
    int repulse;
  } vec_t;

  task automatic run_one(input int num, input int mode, input int exp_done, input int repulse);
    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    int issues, beats, cyc, done_cyc, first_beat, stalls, limit;
    bit prev_stall, prev_last, fin;
    logic [DW-1:0] prev_data;
    issues = 0; beats = 0; cyc = 0; done_cyc = -1; first_beat = -1; stalls = 0;
    prev_stall = 0; prev_last = 0; fin = 0; prev_data = '0;
    limit = num * 4 + 50;
    @(negedge clk);
    i_run = 1'b1;
    i_num_cnt = CNT'(num);
    @(posedge clk);
    cyc = 1;
    while (!fin) begin
      @(negedge clk);
      i_run = (repulse != 0 && cyc == repulse);
      if (i_run) i_num_cnt = CNT'(99);
      case (mode)
        0:       strm.m_ready = 1'b1;
        1:       strm.m_ready = ((cyc - 1) % 3 == 0);
        2:       strm.m_ready = 1'($urandom_range(0, 1));
        default: strm.m_ready = (cyc > 12);
      endcase
      #1;
      if (cyc == 1) check("running_cycle1", o_running, (num > 0));
      if (prev_stall) begin
        check("stall_valid", strm.m_valid, 1);
        check("stall_data", strm.m_data, prev_data);
        check("stall_last", strm.m_last, prev_last);
      end
      check("occupancy", ((issues - beats) <= DEPTH) && (issues >= beats), 1);
      if (ce_b1) begin
        check("ce_addr", addr_b1, issues % MEMSZ);
        issues++;
      end
      if (strm.m_valid && strm.m_ready) begin
        got_data.push_back(strm.m_data);
        got_last.push_back(strm.m_last);
        if (first_beat < 0) first_beat = cyc;
        beats++;
      end
      prev_stall = strm.m_valid && !strm.m_ready;
      prev_data  = strm.m_data;
      prev_last  = strm.m_last;
      if (prev_stall) stalls++;
      if (done_cyc >= 0) begin
        check("idle_after_done", o_idle, 1);
        check("done_one_cycle", o_done, 0);
        fin = 1;
      end else if (o_done) begin
        done_cyc = cyc;
      end
      if (!fin && cyc >= limit) begin
        check("run_timeout", cyc, 0);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk);
        cyc++;
      end
    end
    i_run = 1'b0;
    check("beat_count", beats, num);
    check("issue_count", issues, num);
    // Reference: beat i carries word i of the BRAM image, address modulo the BRAM size.
    foreach (got_data[i]) begin
      check("beat_data", got_data[i], 32'hA000_0000 + (i % MEMSZ));
      check("beat_last", got_last[i], (i == num - 1));
    end
    if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
    if (mode == 0 && num > 0) check("first_beat_cycle", first_beat, 3);
    if (mode == 3) check("stall_cycles", stalls, 10);
  endtask

  vec_t vecs[10];

  initial begin
    int beats;
    bit hit;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 32'hA000_0000 + i;
    strm.m_ready = 1'b0;

    vecs[0] = '{num: 4,    mode: 0, exp_done: 7,    repulse: 0};
    vecs[1] = '{num: 8,    mode: 1, exp_done: 0,    repulse: 0};
    vecs[2] = '{num: 0,    mode: 0, exp_done: 1,    repulse: 0};
    vecs[3] = '{num: 1,    mode: 3, exp_done: 14,   repulse: 0};
    vecs[4] = '{num: 5,    mode: 0, exp_done: 8,    repulse: 3};
    vecs[5] = '{num: 4100, mode: 0, exp_done: 4103, repulse: 0};
    vecs[6] = '{num: 3,    mode: 2, exp_done: 0,    repulse: 0};
    for (int i = 7; i < 10; i++)
      vecs[i] = '{num: int'($urandom_range(1, 40)), mode: int'($urandom_range(0, 2)),
                  exp_done: 0, repulse: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_idle", o_idle, 1);
    check("rst_running", o_running, 0);
    check("rst_done", o_done, 0);
    check("rst_ce", ce_b1, 0);
    check("rst_we", we_b1, 0);
    check("rst_d0", d0_b1, 0);
    check("rst_addr", addr_b1, 0);
    check("rst_valid", strm.m_valid, 0);
    check("rst_data", strm.m_data, 0);
    check("rst_last", strm.m_last, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_one(vecs[i].num, vecs[i].mode, vecs[i].exp_done, vecs[i].repulse);

    // Abort a num=6 run with reset right after its second beat, then rerun cleanly.
    @(negedge clk);
    i_run = 1'b1;
    i_num_cnt = CNT'(6);
    @(posedge clk);
    beats = 0;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      i_run = 1'b0;
      strm.m_ready = 1'b1;
      #1;
      if (strm.m_valid) beats++;
      if (beats == 2) hit = 1;
      else @(posedge clk);
    end
    check("abort_reached_beat2", hit, 1);
    reset_n = 1'b0;
    #1;
    check("abort_idle", o_idle, 1);
    check("abort_running", o_running, 0);
    check("abort_valid", strm.m_valid, 0);
    check("abort_last", strm.m_last, 0);
    check("abort_ce", ce_b1, 0);
    check("abort_done", o_done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_one(3, 0, 6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
